// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the regfile write port among NREQ writeback requesters
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic             we3,
  output logic [AW-1:0]    wa3,
  output logic [DW-1:0]    wd3,
  output logic [CW-1:0]    wr_count,
  output logic             busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PW-1:0] rr_ptr, gidx;
  logic          xfer;
  logic [AW-1:0] ga;
  logic [DW-1:0] gd;
  int            s;
  // scan from rr_ptr upward (mod NREQ); first valid requester wins, grant uses only valid and pointer
  always_comb begin
    xfer = 1'b0;
    gidx = '0;
    ga = '0;
    gd = '0;
    s = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = (int'(rr_ptr) + k) % NREQ;
      if (!xfer && req_valid[s]) begin
        xfer = 1'b1;
        gidx = PW'(s);
        ga = req_addr[s*AW +: AW];
        gd = req_data[s*DW +: DW];
      end
    end
  end
  assign req_ready = (xfer && reset_n) ? NREQ'(1) << gidx : '0;
  assign busy = we3;
  // pointer advance, registered write (r0 writes swallowed), and committed-write counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      wr_count <= '0;
    end else begin
      if (xfer) rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
      we3 <= xfer && (ga != '0);
      if (xfer && ga != '0) begin
        wa3 <= ga;
        wd3 <= gd;
      end
      if (we3) wr_count <= wr_count + CW'(1);
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter (NREQ=2, CW=4)
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [3:0]  wr_count;
  logic        busy;
  int n_chk = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32), .CW(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
    .wr_count(wr_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b11;
    req_addr = '0;
    req_data = '0;
    req(0, 5'd1, 32'hA0);
    req(1, 5'd2, 32'hB0);
    // T1: reset holds everything quiet even with both requesters valid
    cyc();
    cyc();
    #1;
    chk("t1_ready_in_reset", 64'(req_ready), 64'h0);
    chk("t1_we3_in_reset", 64'(we3), 64'h0);
    chk("t1_wr_count_in_reset", 64'(wr_count), 64'h0);
    chk("t1_wa3_in_reset", 64'(wa3), 64'h0);
    chk("t1_wd3_in_reset", 64'(wd3), 64'h0);
    chk("t1_busy_in_reset", 64'(busy), 64'h0);
    reset_n = 1'b1;
    #1;
    chk("t1_first_grant_req0", 64'(req_ready), 64'h1);
    cyc();
    chk("t1_we3", 64'(we3), 64'h1);
    chk("t1_wa3", 64'(wa3), 64'h1);
    chk("t1_wd3", 64'(wd3), 64'hA0);
    chk("t1_wr_count", 64'(wr_count), 64'h0);
    req_valid = 2'b10;
    #1;
    chk("t1_second_grant_req1", 64'(req_ready), 64'h2);
    cyc();
    chk("t1_wa3_req1", 64'(wa3), 64'h2);
    chk("t1_wd3_req1", 64'(wd3), 64'hB0);
    chk("t1_wr_count_1", 64'(wr_count), 64'h1);
    // T2: single zero-wait write from req0
    req_valid = 2'b01;
    req(0, 5'd5, 32'hDEADBEEF);
    #1;
    chk("t2_ready0", 64'(req_ready), 64'h1);
    cyc();
    chk("t2_we3", 64'(we3), 64'h1);
    chk("t2_busy", 64'(busy), 64'h1);
    chk("t2_wa3", 64'(wa3), 64'h5);
    chk("t2_wd3", 64'(wd3), 64'hDEADBEEF);
    chk("t2_wr_count", 64'(wr_count), 64'h2);
    req_valid = 2'b00;
    #1;
    chk("t2_no_valid_no_ready", 64'(req_ready), 64'h0);
    cyc();
    chk("t2_idle_we3", 64'(we3), 64'h0);
    chk("t2_idle_wa3_hold", 64'(wa3), 64'h5);
    chk("t2_idle_wd3_hold", 64'(wd3), 64'hDEADBEEF);
    chk("t2_idle_wr_count", 64'(wr_count), 64'h3);
    // realign pointer to 0 with one req1 write
    req_valid = 2'b10;
    req(1, 5'd7, 32'h77);
    #1;
    chk("align_ready1", 64'(req_ready), 64'h2);
    cyc();
    chk("align_wa3", 64'(wa3), 64'h7);
    chk("align_wr_count", 64'(wr_count), 64'h3);
    // T3: sustained contention alternates 0,1,0,1
    req_valid = 2'b11;
    req(0, 5'd1, 32'h11);
    req(1, 5'd2, 32'h22);
    #1;
    chk("t3_grant_a", 64'(req_ready), 64'h1);
    cyc();
    chk("t3_wa3_a", 64'(wa3), 64'h1);
    chk("t3_wd3_a", 64'(wd3), 64'h11);
    chk("t3_grant_b", 64'(req_ready), 64'h2);
    cyc();
    chk("t3_wa3_b", 64'(wa3), 64'h2);
    chk("t3_grant_c", 64'(req_ready), 64'h1);
    cyc();
    chk("t3_wa3_c", 64'(wa3), 64'h1);
    chk("t3_grant_d", 64'(req_ready), 64'h2);
    cyc();
    chk("t3_wa3_d", 64'(wa3), 64'h2);
    chk("t3_wd3_d", 64'(wd3), 64'h22);
    chk("t3_we3_d", 64'(we3), 64'h1);
    chk("t3_wr_count", 64'(wr_count), 64'h7);
    #1;
    chk("t3_ptr_back_at_0", 64'(req_ready), 64'h1);
    // T4: write to r0 is accepted but discarded
    req_valid = 2'b10;
    req(1, 5'd0, 32'h1234);
    #1;
    chk("t4_ready1", 64'(req_ready), 64'h2);
    cyc();
    req_valid = 2'b00;
    chk("t4_we3_low", 64'(we3), 64'h0);
    chk("t4_wa3_hold", 64'(wa3), 64'h2);
    chk("t4_wd3_hold", 64'(wd3), 64'h22);
    chk("t4_wr_count", 64'(wr_count), 64'h8);
    cyc();
    chk("t4_wr_count_unchanged", 64'(wr_count), 64'h8);
    // T5: async reset with a write being presented
    req_valid = 2'b01;
    req(0, 5'd9, 32'h99);
    cyc();
    chk("t5_we3_before", 64'(we3), 64'h1);
    chk("t5_wa3_before", 64'(wa3), 64'h9);
    chk("t5_wr_count_before", 64'(wr_count), 64'h8);
    req(0, 5'd10, 32'hAA);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_we3_async", 64'(we3), 64'h0);
    chk("t5_wa3_async", 64'(wa3), 64'h0);
    chk("t5_wd3_async", 64'(wd3), 64'h0);
    chk("t5_wr_count_async", 64'(wr_count), 64'h0);
    chk("t5_ready_async", 64'(req_ready), 64'h0);
    cyc();
    chk("t5_no_commit_we3", 64'(we3), 64'h0);
    chk("t5_no_commit_count", 64'(wr_count), 64'h0);
    reset_n = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("t5_ptr_reset_to_0", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    // T6: 16 back-to-back writes to the same register, counter wraps 15 -> 0
    for (int k = 1; k <= 16; k++) begin
      req_valid = 2'b01;
      req(0, 5'd3, 32'(k));
      #1;
      chk("t6_ready", 64'(req_ready), 64'h1);
      cyc();
      chk("t6_we3", 64'(we3), 64'h1);
      chk("t6_wa3", 64'(wa3), 64'h3);
      chk("t6_wd3", 64'(wd3), 64'(k));
      chk("t6_wr_count", 64'(wr_count), 64'((k - 1) & 15));
    end
    req_valid = 2'b00;
    cyc();
    chk("t6_wrap_to_0", 64'(wr_count), 64'h0);
    chk("t6_we3_idle", 64'(we3), 64'h0);
    chk("t6_last_value_wins", 64'(wd3), 64'h10);
    cyc();
    chk("t6_count_stays_0", 64'(wr_count), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
